sample_delay_line_mc: RTL and testbench
=======================================

Name: sample_delay_line_mc

Overview:
- Multi-channel, runtime-programmable sample delay line for the xpu receive path.
- Aligns NUM_CH parallel sample streams to a delayed copy of themselves, for example to compensate for detection latency before the sample stream is gated.
- Replaces the fifo-based single-shot delay with an inferred circular RAM.
- Supports delay changes on the fly, zero-delay bypass, and immediate validity when enough history is already stored.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- NUM_CH, 2, number of lock-step channels sharing one valid strobe.
- LOG2_DEPTH, 7, log2 of ring depth; maximum delay is (1<<LOG2_DEPTH)-1 samples.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- delay_ctl  input  LOG2_DEPTH  requested delay in valid samples (0 = bypass).
- data_in  input  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- data_in_valid  input  1  sample strobe; one write per asserted cycle.
- data_out  output  NUM_CH*DATA_WIDTH  delayed samples, same packing.
- data_out_valid  output  1  data_out carries a valid delayed sample this cycle.
- primed  output  1  enough history is stored for the current delay.
- delay_active  output  LOG2_DEPTH  delay currently in force.

Behaviour:
- Reset values: data_out=0, data_out_valid=0, primed=0, delay_active=0. Internally, wr_ptr=0 and fill_cnt=0; RAM contents are don't-care.
- Delay register:
  - delay_active <= delay_ctl every cycle (1-cycle registration).
  - The registered value applies to the first valid sample in the following cycle.
- Write side: on data_in_valid, RAM[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1, wrapping modulo 2^LOG2_DEPTH.
- Read side:
  - read address = (wr_ptr - delay_active) mod 2^LOG2_DEPTH, computed with the pre-increment wr_ptr of the same cycle.
  - For D>0 this address never equals wr_ptr, so there is no read-during-write collision.
- fill_cnt:
  - Counts samples written since reset, width LOG2_DEPTH.
  - Increments on data_in_valid and saturates at 2^LOG2_DEPTH-1.
- primed = (fill_cnt >= delay_active), combinational from registers.
- Output timing (latency exactly 1 clk after the data_in_valid cycle, for every delay value):
  - If data_in_valid and primed: data_out_valid <= 1 and data_out <= (delay_active==0 ? data_in : RAM[read address]).
  - Otherwise: data_out_valid <= 0 and data_out holds its previous value.
- Delay semantics: for the n-th valid input x[n] (n from 0 after reset), the output produced one clk later is x[n-D].
- Delay change mid-stream:
  - No flush and no refill wait.
  - If the new D <= fill_cnt, the output is valid immediately, with the sample x[n-Dnew]. Samples may be repeated (D increases) or skipped (D decreases); this is intended.
  - If the new D > fill_cnt, data_out_valid stays low until fill_cnt reaches D.
- Gaps in data_in_valid do not advance the delay: the delay is counted in samples, not clocks.
- Wrap-around: wr_ptr wraps silently. Once fill_cnt has saturated, every delay value 0..2^LOG2_DEPTH-1 is permanently primed.
- Reset mid-stream: pointers and fill_cnt clear in the reset cycle. The first post-reset output for D>0 appears only after D new writes; stale RAM data is never emitted.
- All channels share pointers and valid, so they stay in lock-step.
- RAM is inferred (distributed or block). An asynchronous-read array plus output register is sufficient.

Test Plan:
- Priming: rst, delay_ctl=5, feed an incrementing ramp 0,1,2,... with continuous valid. Required response:
  - data_out_valid first asserts one clk after the input sample 5;
  - data_out=0 at that point, then tracks x-5 every cycle.
- Bypass: delay_ctl=0, valid every other cycle, input 0xA5 then 0x5A. Required response: data_out equals data_in one clk later, and data_out_valid mirrors data_in_valid delayed by 1.
- Delay change: with D=10 primed (fill_cnt≥20), switch delay_ctl to 3. Required response:
  - two cycles later the output equals x[n-3] with no invalid gap;
  - switching to 100 drops valid until 100 samples exist in total.
- Wrap and maximum delay: LOG2_DEPTH=7, D=127, stream 300 samples. Required response: outputs equal x[n-127] across both pointer wraps, with no glitch at wr_ptr=0.
- Multi-channel and gapped input: NUM_CH=4, channel c = ramp+c*1000, random valid gaps, D=7. Required response: every channel equals its own input delayed by 7 samples, and gaps do not shift the alignment.
- Reset mid-stream: assert rst for 1 clk after 50 samples at D=4. Required response:
  - data_out_valid=0 and data_out=0 next cycle;
  - the next valid output is the 5th post-reset sample's x[0], with no pre-reset data emitted.

Source files
------------

// File: rtl/sample_delay_line_mc.sv
// rtl/sample_delay_line_mc.sv - multi-channel runtime-programmable sample delay line on a circular RAM
module sample_delay_line_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int LOG2_DEPTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LOG2_DEPTH-1:0]        delay_ctl,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         primed,
    output logic [LOG2_DEPTH-1:0]        delay_active
);

    localparam int W     = NUM_CH * DATA_WIDTH;
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);

    logic [W-1:0]          ram [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [LOG2_DEPTH-1:0] delay_q, delay_d;
    logic [LOG2_DEPTH-1:0] rd_addr;
    logic [W-1:0]          data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  enough_hist;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        delay_d     = delay_ctl;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        // Pre-increment pointer minus delay; for nonzero delay this never hits the write slot.
        rd_addr     = wr_ptr_q - delay_q;
        enough_hist = (fill_cnt_q >= delay_q);
        if (data_in_valid) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fill_cnt_q != '1) begin
                fill_cnt_d = fill_cnt_q + PTR_ONE;
            end
            if (enough_hist) begin
                valid_d    = 1'b1;
                data_out_d = (delay_q == '0) ? data_in : ram[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            delay_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            delay_q    <= delay_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // RAM contents are never cleared; fill_cnt alone keeps stale entries from being read.
    always_ff @(posedge clk) begin
        if (!rst && data_in_valid) begin
            ram[wr_ptr_q] <= data_in;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign primed         = ~rst & enough_hist;
    assign delay_active   = delay_q;

endmodule

// File: tb/tb_sample_delay_line_mc.sv
// tb/tb_sample_delay_line_mc.sv - randomized bench for sample_delay_line_mc against a sample-history model
module tb_sample_delay_line_mc;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int LD = 7;
    localparam int W  = NC * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LD-1:0] delay_ctl = '0;
    logic [W-1:0]  data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_out_valid;
    logic          primed;
    logic [LD-1:0] delay_active;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0]  hist[$];
    int            d_reg = 0;
    logic          exp_valid = 1'b0;
    logic [W-1:0]  exp_data = '0;
    logic          exp_primed;

    sample_delay_line_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .LOG2_DEPTH(LD)) dut (
        .clk(clk), .rst(rst), .delay_ctl(delay_ctl), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_out(data_out),
        .data_out_valid(data_out_valid), .primed(primed), .delay_active(delay_active)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ramp_word(input int base);
        logic [W-1:0] w;
        for (int c = 0; c < NC; c++) w[c*DW +: DW] = DW'(base + c * 1000);
        return w;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int c = 0; c < NC; c++) w[c*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    // Drives one clock of stimulus and advances the model: output n is x[n-D] when n >= D.
    task automatic step(input logic r, input logic v, input logic [W-1:0] x, input int dc);
        rst = r; data_in_valid = v; data_in = x; delay_ctl = LD'(dc);
        @(posedge clk);
        if (r) begin
            exp_valid = 1'b0; exp_data = '0; hist.delete(); d_reg = 0;
        end else begin
            exp_valid = v && (hist.size() >= d_reg);
            if (exp_valid) exp_data = (d_reg == 0) ? x : hist[hist.size() - d_reg];
            if (v) hist.push_back(x);
            d_reg = dc;
        end
        exp_primed = !r && (hist.size() >= d_reg);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, rand_word(), 9);
        step(1'b1, 1'b0, '0, 9);
        vectors++;
        if (data_out_valid !== 1'b0 || data_out !== '0) begin
            miscompares++;
            $display("FAIL reset_out valid=%b data=%h required valid=0 data=0", data_out_valid, data_out);
        end
        vectors++;
        if (primed !== 1'b0 || delay_active !== '0) begin
            miscompares++;
            $display("FAIL reset_status primed=%b delay=%0d required primed=0 delay=0", primed, delay_active);
        end
    endtask

    task automatic test_priming();
        int first_valid = -1;
        step(1'b1, 1'b0, '0, 5);
        step(1'b0, 1'b0, '0, 5);
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 1'b1, ramp_word(n), 5);
            if (data_out_valid === 1'b1 && first_valid < 0) first_valid = n;
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL priming n=%0d got %b/%h required %b/%h", n, data_out_valid, data_out, exp_valid, exp_data);
            end
        end
        vectors++;
        if (first_valid !== 5) begin
            miscompares++;
            $display("FAIL priming_first_valid got sample %0d required sample 5", first_valid);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] pat;
        step(1'b1, 1'b0, '0, 0);
        for (int i = 0; i < 24; i++) begin
            pat = (i % 4 == 0) ? {NC{16'h00A5}} : {NC{16'h005A}};
            step(1'b0, (i % 2) == 0, pat, 0);
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL bypass i=%0d got %b/%h required %b/%h", i, data_out_valid, data_out, exp_valid, exp_data);
            end
        end
    endtask

    task automatic test_delay_change();
        int dc;
        step(1'b1, 1'b0, '0, 10);
        step(1'b0, 1'b0, '0, 10);
        for (int i = 0; i < 160; i++) begin
            dc = (i < 25) ? 10 : (i < 40) ? 3 : 100;
            step(1'b0, 1'b1, rand_word(), dc);
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL delay_change i=%0d got %b/%h required %b/%h", i, data_out_valid, data_out, exp_valid, exp_data);
            end
            vectors++;
            if (primed !== exp_primed || delay_active !== LD'(d_reg)) begin
                miscompares++;
                $display("FAIL delay_change_status i=%0d got %b/%0d required %b/%0d", i, primed, delay_active, exp_primed, d_reg);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, '0, 127);
        step(1'b0, 1'b0, '0, 127);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, rand_word(), 127);
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL wrap i=%0d got %b/%h required %b/%h", i, data_out_valid, data_out, exp_valid, exp_data);
            end
        end
        vectors++;
        if (primed !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_primed got %b required 1", primed);
        end
    endtask

    task automatic test_multich_gapped();
        int n = 0;
        logic v;
        step(1'b1, 1'b0, '0, 7);
        step(1'b0, 1'b0, '0, 7);
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(2) != 0);
            step(1'b0, v, v ? ramp_word(n) : rand_word(), 7);
            if (v) n++;
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL multich i=%0d got %b/%h required %b/%h", i, data_out_valid, data_out, exp_valid, exp_data);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int first_valid = -1;
        step(1'b1, 1'b0, '0, 4);
        step(1'b0, 1'b0, '0, 4);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, ramp_word(500 + i), 4);
        step(1'b1, 1'b1, ramp_word(999), 4);
        step(1'b0, 1'b0, '0, 4);
        vectors++;
        if (data_out_valid !== 1'b0 || data_out !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear got %b/%h required 0/0", data_out_valid, data_out);
        end
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 1'b1, ramp_word(n), 4);
            if (data_out_valid === 1'b1 && first_valid < 0) first_valid = n;
            vectors++;
            if (data_out_valid !== exp_valid || data_out !== exp_data) begin
                miscompares++;
                $display("FAIL midreset n=%0d got %b/%h required %b/%h", n, data_out_valid, data_out, exp_valid, exp_data);
            end
        end
        vectors++;
        if (first_valid !== 4) begin
            miscompares++;
            $display("FAIL midreset_first_valid got sample %0d required sample 4", first_valid);
        end
    endtask

    initial begin
        test_reset();
        test_priming();
        test_bypass();
        test_delay_change();
        test_wrap();
        test_multich_gapped();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
